// File: rtl/ifetch_queue.sv
// ifetch_queue: pipelined instruction fetch with a DEPTH-entry prefetch queue.
// Optional perf counters under `define IFETCH_PERF_CNT_EN.
module ifetch_queue #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            BRANCH,
  input  logic            ALU_Z,
  input  logic [XLEN-1:0] SE_PC,
  input  logic [XLEN-1:0] SE_B,
  input  logic            ret_enable,
  input  logic [XLEN-1:0] QT_B
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] ALIGN =
    ~XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] tag_pc [DEPTH];
  logic [AW-1:0]   q_rd, q_wr;
  logic [AW-1:0]   t_rd, t_wr;
  logic [CW-1:0]   q_cnt, q_cnt_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            credit;
  logic            issue;
  logic            drop;
  logic            push;
  logic            pop;

  assign redirect = ret_enable | (BRANCH & ALU_Z);
  assign target   = (ret_enable ? QT_B : SE_PC + SE_B)
                  & ALIGN;

  // Count in-flight requests against queue space so a response always fits.
  assign credit = ({1'b0, q_cnt} + {1'b0, outstanding})
                < (CW+1)'(DEPTH);

  assign imem_req  = rst_n & credit & ~redirect;
  assign imem_addr = pc_q;
  assign issue     = imem_req & imem_gnt;

  assign drop = imem_rvalid & (drop_cnt != '0);
  assign push = imem_rvalid & ~drop & ~redirect;

  assign inst_valid = q_cnt != '0;
  assign pop        = inst_valid & inst_ready & ~redirect;
  assign inst_data  = inst_valid ? q_data[q_rd] : '0;
  assign inst_pc    = inst_valid ? q_pc[q_rd]   : '0;

  always_comb begin
    q_cnt_d = q_cnt;
    unique case (1'b1)
      redirect:    q_cnt_d = '0;
      push & ~pop: q_cnt_d = q_cnt + CW'(1);
      pop & ~push: q_cnt_d = q_cnt - CW'(1);
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      q_cnt       <= q_cnt_d;
      outstanding <= outstanding + CW'(issue)
                   - CW'(imem_rvalid);
      if (redirect) begin
        pc_q     <= target;
        q_rd     <= '0;
        q_wr     <= '0;
        t_rd     <= '0;
        t_wr     <= '0;
        // Everything still in flight belongs to the old stream.
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (issue) begin
          pc_q <= pc_q + XLEN'(INSTR_BYTES);
          t_wr <= t_wr + AW'(1);
        end
        if (drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          q_wr <= q_wr + AW'(1);
          t_rd <= t_rd + AW'(1);
        end
        if (pop) q_rd <= q_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_pc[t_wr] <= pc_q;
    if (push) begin
      q_data[q_wr] <= imem_rdata;
      q_pc[q_wr]   <= tag_pc[t_rd];
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && q_cnt == CW'(DEPTH)));

`ifdef IFETCH_PERF_CNT_EN
  logic [32:0] fl_sum;
  logic        fl_drop;

  assign fl_drop = imem_rvalid & (drop | redirect);

  always_comb begin
    fl_sum = {1'b0, perf_flushed} + 33'(fl_drop);
    if (redirect) fl_sum = fl_sum + 33'(q_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= fl_sum[32] ? '1 : fl_sum[31:0];
    end
  end
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised instruction-fetch stage that succeeds the single-instruction fetch block. It holds the PC and issues pipelined requests to instruction memory with a request/grant handshake. Returned words are buffered in a DEPTH-entry prefetch queue that feeds decode through a valid/ready interface. Taken branches (BRANCH & ALU_Z) and returns (ret_enable) redirect the PC, flush the queue and discard in-flight responses.

Parameters:
XLEN, 32, data/address width in bits
DEPTH, 4, prefetch queue entries; power of two, >= 2
INSTR_BYTES, 4, PC increment per instruction; power of two
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (current PC)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in order, latency >= 1 cycle
imem_rdata  in  XLEN  response instruction word
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction
BRANCH  in  1  conditional branch resolved this cycle
ALU_Z  in  1  ALU zero flag; branch taken when BRANCH & ALU_Z
SE_PC  in  XLEN  PC of the branch instruction
SE_B  in  XLEN  sign-extended branch byte offset
ret_enable  in  1  return: redirect to QT_B
QT_B  in  XLEN  return target (register value)

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC; queue empty; outstanding=0; drop_cnt=0; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst_data=0; inst_pc=0. Reset mid-transaction abandons all in-flight requests; the memory side must be reset with the same rst_n.
- imem_addr = pc_q combinationally.
- Issue: imem_req=1 when (count + outstanding) < DEPTH and no redirect is active this cycle. On imem_req & imem_gnt: pc_q += INSTR_BYTES (modulo 2^XLEN wrap) and outstanding += 1. The fetch PC is pushed into a side FIFO for tagging.
- Response: on imem_rvalid: outstanding -= 1. If drop_cnt > 0, decrement drop_cnt and discard the word. Otherwise push {rdata, tagged PC} into the queue. The credit rule guarantees space; a push to a full queue is an assertion failure.
- Output: inst_valid = count != 0. inst_data and inst_pc show the head entry, or zeros when empty. Pop on inst_valid & inst_ready. Push and pop in the same cycle keep count unchanged. Earliest head visibility is the cycle after rvalid.
- Redirect: redirect = ret_enable | (BRANCH & ALU_Z). If both conditions hold, ret_enable has priority.
  - Target = ret_enable ? QT_B : SE_PC + SE_B. Target low log2(INSTR_BYTES) bits are forced to 0.
  - On the redirect edge: pc_q = target; queue and PC-tag FIFO are cleared; any rvalid in the same cycle is discarded.
  - drop_cnt = outstanding - (imem_rvalid ? 1 : 0) + existing drop_cnt accounting. Every request still in flight is dropped; a new redirect while drop_cnt > 0 adds only new outstanding requests.
  - imem_req is forced to 0 in the redirect cycle. A pop in that cycle is legal but has no effect beyond the flush.
- BRANCH with ALU_Z=0: no action.
- Single cycle redirect-to-request: imem_req may assert with the new pc_q in the cycle after redirect.

Optional Feature:
IFETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32 bits) and perf_flushed (32 bits), both reset to 0 and saturating. perf_fetched counts queue pops. perf_flushed counts entries cleared from the queue plus responses discarded via drop_cnt.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, 1-cycle memory, gnt=1, inst_ready=1 -> imem_addr 0x0,0x4,0x8,... on consecutive cycles; inst_pc/inst_data follow with 2-cycle latency, one per cycle.
- inst_ready=0 with DEPTH=4 -> exactly 4 requests granted, then imem_req=0; count=4; requests resume the cycle after the first pop.
- Branch with SE_PC=0x10, SE_B=0x20, BRANCH=1, ALU_Z=1, 2 requests in flight -> next imem_addr=0x30; both stale responses dropped; first inst_pc=0x30.
- ret_enable=1 with QT_B=0x103 together with a taken branch -> target 0x100 (ret priority, aligned); queue flushed.
- BRANCH=1, ALU_Z=0 -> no flush; sequential PCs continue.
- rst_n pulled low with 3 outstanding requests and a full queue -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC with no stale instruction delivered.
